// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: opcode decoder with a valid/ready output stage and
// fixed-latency countdown for MUL and DIV/MOD before the control bundle is presented.
module pipe_ctrl_unit #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  opcode,
  input  logic        imm,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [21:0] ctrl,
  output logic        illegal,
  output logic        busy
);
  typedef enum logic [1:0] {EMPTY, HOLD, WAIT} state_t;
  state_t state;
  logic [3:0] cnt, lat;
  logic [21:0] dec, pend;
  logic wb, take;
  always_comb begin
    in_ready = !flush && (state == EMPTY || (state == HOLD && out_ready));
    take = in_valid && in_ready;
    wb = opcode <= 5'd4 || (opcode >= 5'd6 && opcode <= 5'd12) || opcode == 5'd14 || opcode == 5'd19;
    dec = {opcode == 5'd9, opcode == 5'd8, opcode == 5'd6, opcode == 5'd7,
           opcode == 5'd12, opcode == 5'd11, opcode == 5'd10,
           opcode == 5'd4, opcode == 5'd3, opcode == 5'd2, opcode == 5'd5, opcode == 5'd1,
           opcode == 5'd0 || opcode == 5'd14 || opcode == 5'd15,
           opcode == 5'd19, opcode >= 5'd18 && opcode <= 5'd20, wb, imm,
           opcode == 5'd20, opcode == 5'd17, opcode == 5'd16, opcode == 5'd14, opcode == 5'd15};
    lat = opcode == 5'd2 ? MUL_LAT[3:0] : (opcode == 5'd3 || opcode == 5'd4) ? DIV_LAT[3:0] : 4'd1;
  end
  assign out_valid = state == HOLD;
  assign busy = state == WAIT;
  // ctrl stays zero during WAIT; the decoded bundle parks in pend until the countdown ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt <= 4'd0;
      ctrl <= 22'd0;
      pend <= 22'd0;
      illegal <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
      cnt <= 4'd0;
      ctrl <= 22'd0;
      illegal <= 1'b0;
    end else if (take && lat > 4'd1) begin
      state <= WAIT;
      cnt <= lat - 4'd1;
      pend <= dec;
      ctrl <= 22'd0;
      illegal <= 1'b0;
    end else if (take) begin
      state <= HOLD;
      ctrl <= dec;
      illegal <= opcode >= 5'd21;
    end else if (state == HOLD && out_ready) begin
      state <= EMPTY;
      ctrl <= 22'd0;
      illegal <= 1'b0;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        state <= HOLD;
        ctrl <= pend;
      end
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: table vectors, directed corner sequences and random traffic
// checked against a cycle-level behavioural model of the decode and handshake rules.
module tb_pipe_ctrl_unit;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;
  localparam logic [21:0] ST = 22'd1 << 0, LD = 22'd1 << 1, BEQ = 22'd1 << 2, BGT = 22'd1 << 3,
    RET = 22'd1 << 4, IMM = 22'd1 << 5, WB = 22'd1 << 6, UB = 22'd1 << 7, CALL = 22'd1 << 8,
    ADD = 22'd1 << 9, SUB = 22'd1 << 10, CMP = 22'd1 << 11, MUL = 22'd1 << 12, DIV = 22'd1 << 13,
    MOD = 22'd1 << 14, LSL = 22'd1 << 15, LSR = 22'd1 << 16, ASR = 22'd1 << 17, OR = 22'd1 << 18,
    AND = 22'd1 << 19, NOT = 22'd1 << 20, MOV = 22'd1 << 21;
  logic clk = 0, rst_n = 0, in_valid = 0, imm = 0, flush = 0, out_ready = 0;
  logic [4:0] opcode = 0;
  logic in_ready, out_valid, illegal, busy;
  logic [21:0] ctrl;
  int checks = 0, errors = 0;
  bit m_has = 0, m_ill = 0;
  int m_due = 0;
  logic [21:0] m_ctrl = 0;
  pipe_ctrl_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .imm(imm), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ctrl(ctrl),
    .illegal(illegal), .busy(busy));
  always #5 clk = ~clk;
  function automatic logic [21:0] mdec(input logic [4:0] op, input logic im);
    logic [21:0] f;
    case (op)
      0: f = ADD | WB;   1: f = SUB | WB;   2: f = MUL | WB;   3: f = DIV | WB;
      4: f = MOD | WB;   5: f = CMP;        6: f = AND | WB;   7: f = OR | WB;
      8: f = NOT | WB;   9: f = MOV | WB;   10: f = LSL | WB;  11: f = LSR | WB;
      12: f = ASR | WB;  14: f = LD | ADD | WB;  15: f = ST | ADD;  16: f = BEQ;
      17: f = BGT;       18: f = UB;        19: f = UB | CALL | WB;  20: f = UB | RET;
      default: f = '0;
    endcase
    return im ? f | IMM : f;
  endfunction
  function automatic int mlat(input logic [4:0] op);
    return op == 2 ? MUL_LAT : (op == 3 || op == 4) ? DIV_LAT : 1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic step(input bit iv, input logic [4:0] op, input bit im, input bit fl, input bit ordy);
    bit exp_rdy, ov;
    in_valid = iv; opcode = op; imm = im; flush = fl; out_ready = ordy;
    #1;
    exp_rdy = !fl && (!m_has || (m_due == 0 && ordy));
    chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (fl) m_has = 0;
    else begin
      if (m_has && m_due == 0 && ordy) m_has = 0;
      else if (m_has && m_due > 0) m_due--;
      if (iv && exp_rdy) begin
        m_has = 1; m_due = mlat(op) - 1; m_ctrl = mdec(op, im); m_ill = op > 20;
      end
    end
    #1;
    ov = m_has && m_due == 0;
    chk("out_valid", out_valid, ov);
    chk("busy", busy, m_has && m_due > 0);
    chk("ctrl", ctrl, ov ? m_ctrl : 22'd0);
    chk("illegal", illegal, ov && m_ill);
  endtask
  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0;
    rst_n = 0;
    #1;
    m_has = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  typedef struct { logic [4:0] op; logic im; logic [21:0] ctrl; logic ill; } vec_t;
  vec_t tab[11];
  initial begin
    int n;
    tab[0] = '{5'd14, 1'b1, 22'h000262, 1'b0};
    tab[1] = '{5'd25, 1'b0, 22'h000000, 1'b1};
    tab[2] = '{5'd25, 1'b1, 22'h000020, 1'b1};
    tab[3] = '{5'd19, 1'b0, 22'h0001C0, 1'b0};
    tab[4] = '{5'd15, 1'b0, 22'h000201, 1'b0};
    tab[5] = '{5'd5,  1'b1, 22'h000820, 1'b0};
    tab[6] = '{5'd13, 1'b0, 22'h000000, 1'b0};
    tab[7] = '{5'd0,  1'b0, 22'h000240, 1'b0};
    tab[8] = '{5'd20, 1'b0, 22'h000090, 1'b0};
    tab[9] = '{5'd12, 1'b0, 22'h020040, 1'b0};
    tab[10] = '{5'd9, 1'b0, 22'h200040, 1'b0};
    #2;
    do_reset();
    foreach (tab[i]) begin
      step(1, tab[i].op, tab[i].im, 0, 1);
      chk("tab_valid", out_valid, 1);
      chk("tab_ctrl", ctrl, tab[i].ctrl);
      chk("tab_illegal", illegal, tab[i].ill);
      step(0, 0, 0, 0, 1);
    end
    step(1, 5'd3, 0, 0, 1);
    n = 1;
    while (!out_valid && n < 20) begin
      step(1, 5'd0, 0, 0, 0);
      n++;
    end
    chk("div_latency", n, DIV_LAT);
    chk("div_flag", ctrl[13], 1);
    step(0, 0, 0, 0, 1);
    step(1, 5'd6, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 5'd7, 0, 0, 0);
      chk("bp_stable", ctrl, 22'h080040);
    end
    step(1, 5'd0, 0, 0, 1);
    chk("stream_add", ctrl, 22'h000240);
    step(1, 5'd1, 0, 0, 1);
    chk("stream_sub", ctrl, 22'h000440);
    step(1, 5'd6, 0, 0, 1);
    chk("stream_and", ctrl, 22'h080040);
    step(0, 0, 0, 0, 1);
    step(1, 5'd2, 0, 0, 1);
    chk("mul_busy", busy, 1);
    step(1, 5'd0, 0, 1, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    step(0, 0, 0, 0, 1);
    step(1, 5'd9, 0, 0, 0);
    chk("hold_before_rst", out_valid, 1);
    do_reset();
    step(0, 0, 0, 0, 1);
    chk("no_bundle_after_rst", out_valid, 0);
    for (int k = 0; k < 800; k++)
      step($urandom % 4 != 0, ($urandom % 3 == 0) ? 5'($urandom_range(2, 4)) : 5'($urandom % 32),
           1'($urandom % 2), $urandom % 16 == 0, $urandom % 3 != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
